// File: rtl/array_packed_reader.sv
// Streaming reader: loads one packed [WA-1:0][WB-1:0] image,
// then emits a run of elements with modulo-WA index walk.
module array_packed_reader #(
  parameter int WA = 8,
  parameter int WB = 8,
  localparam int IW = $clog2(WA),
  localparam int CW = $clog2(WA + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [WA*WB-1:0] in_dat,
  input  logic [IW-1:0]    in_idx,
  input  logic             in_dir,
  input  logic [CW-1:0]    in_cnt,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WB-1:0]    out_dat,
  output logic [IW-1:0]    out_idx,
  output logic             out_lst
);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  localparam logic [IW-1:0] IDX_MAX = IW'(WA - 1);
  localparam logic [CW-1:0] CNT_ALL = CW'(WA);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  state_t                  state_q, state_d;
  logic [WA-1:0][WB-1:0]   mem_q, mem_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic                    dir_q, dir_d;
  logic [CW-1:0]           rem_q, rem_d;

  // State register with asynchronous clear of all buffered state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mem_q   <= '0;
      idx_q   <= '0;
      dir_q   <= 1'b0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      mem_q   <= mem_d;
      idx_q   <= idx_d;
      dir_q   <= dir_d;
      rem_q   <= rem_d;
    end
  end

  // Load capture, count/index clamping and modulo-WA index walk
  always_comb begin
    state_d = state_q;
    mem_d   = mem_q;
    idx_d   = idx_q;
    dir_d   = dir_q;
    rem_d   = rem_q;
    unique case (state_q)
      IDLE: begin
        if (in_vld) begin
          mem_d = in_dat;
          dir_d = in_dir;
          if ({1'b0, in_idx} > {1'b0, IDX_MAX})
            idx_d = IDX_MAX;
          else
            idx_d = in_idx;
          if (in_cnt == '0 ||
              {1'b0, in_cnt} > {1'b0, CNT_ALL})
            rem_d = CNT_ALL;
          else
            rem_d = in_cnt;
          state_d = SEND;
        end
      end
      SEND: begin
        if (out_rdy) begin
          if (rem_q == CNT_ONE)
            state_d = IDLE;
          else
            rem_d = rem_q - CNT_ONE;
          if (!dir_q)
            idx_d = (idx_q == IDX_MAX) ? '0
                                       : idx_q + IW'(1);
          else
            idx_d = (idx_q == '0) ? IDX_MAX
                                  : idx_q - IW'(1);
        end
      end
    endcase
  end

  // Outputs decoded from registered state only
  always_comb begin
    in_rdy  = (state_q == IDLE);
    out_vld = (state_q == SEND);
    out_dat = mem_q[idx_q];
    out_idx = idx_q;
    out_lst = (state_q == SEND) && (rem_q == CNT_ONE);
  end

endmodule

// File: tb/tb_array_packed_reader.sv
// Self-checking bench for array_packed_reader (WA=8, WB=8)
// with directed scenarios and randomized transactions.
module tb_array_packed_reader;

  localparam int WA = 8;
  localparam int WB = 8;

  logic        clk;
  logic        rst;
  logic        in_vld;
  logic        in_rdy;
  logic [63:0] in_dat;
  logic [2:0]  in_idx;
  logic        in_dir;
  logic [3:0]  in_cnt;
  logic        out_vld;
  logic        out_rdy;
  logic [7:0]  out_dat;
  logic [2:0]  out_idx;
  logic        out_lst;

  int total;
  int bad;

  array_packed_reader #(.WA(WA), .WB(WB)) dut (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (in_vld),
    .in_rdy  (in_rdy),
    .in_dat  (in_dat),
    .in_idx  (in_idx),
    .in_dir  (in_dir),
    .in_cnt  (in_cnt),
    .out_vld (out_vld),
    .out_rdy (out_rdy),
    .out_dat (out_dat),
    .out_idx (out_idx),
    .out_lst (out_lst)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h",
               tag, obs, exp);
    end
  endtask

  // mode 0: always ready, 1: ready 1,0,0 repeating,
  // 2: random ready. abort_after>0 returns after that
  // many handshakes (just after the clock edge).
  task automatic run_txn(input logic [63:0] dat,
                         input int idx,
                         input bit dir,
                         input int cnt,
                         input int mode,
                         input int abort_after);
    int n;
    int k;
    int cyc;
    int ei;
    bit r;
    n = (cnt == 0 || cnt > WA) ? WA : cnt;
    chk("load_rdy", in_rdy, 1);
    in_vld = 1'b1;
    in_dat = dat;
    in_idx = idx[2:0];
    in_dir = dir;
    in_cnt = cnt[3:0];
    @(posedge clk);
    #1;
    in_vld = 1'b0;
    in_dat = '1;
    k = 0;
    cyc = 0;
    while (k < n) begin
      @(negedge clk);
      if (dir)
        ei = (((idx - k) % WA) + WA) % WA;
      else
        ei = (idx + k) % WA;
      chk("out_vld", out_vld, 1);
      chk("out_idx", out_idx, ei);
      chk("out_dat", out_dat, dat[ei*8 +: 8]);
      chk("out_lst", out_lst, (k == n - 1));
      chk("busy_rdy", in_rdy, 0);
      if (mode == 0)
        r = 1'b1;
      else if (mode == 1)
        r = (cyc % 3 == 0);
      else
        r = 1'($urandom_range(0, 1));
      out_rdy = r;
      @(posedge clk);
      #1;
      cyc++;
      if (r) k++;
      if (abort_after != 0 && k == abort_after) begin
        out_rdy = 1'b0;
        return;
      end
      if (cyc > 200) begin
        chk("timeout", 0, 1);
        break;
      end
    end
    out_rdy = 1'b0;
    @(negedge clk);
    chk("done_rdy", in_rdy, 1);
    chk("done_vld", out_vld, 0);
  endtask

  localparam logic [63:0] IMG = 64'h1716151413121110;

  initial begin
    total   = 0;
    bad     = 0;
    clk     = 1'b0;
    rst     = 1'b1;
    in_vld  = 1'b0;
    in_dat  = '0;
    in_idx  = '0;
    in_dir  = 1'b0;
    in_cnt  = '0;
    out_rdy = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_in_rdy", in_rdy, 1);
      chk("rst_out_vld", out_vld, 0);
      chk("rst_out_dat", out_dat, 0);
      chk("rst_out_idx", out_idx, 0);
      chk("rst_out_lst", out_lst, 0);
    end

    run_txn(IMG, 0, 1'b0, 0, 0, 0);
    @(negedge clk);
    run_txn(IMG, 2, 1'b1, 4, 0, 0);
    @(negedge clk);
    run_txn(IMG, 6, 1'b0, 12, 1, 0);
    @(negedge clk);

    run_txn(IMG, 0, 1'b0, 0, 0, 3);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_out_vld", out_vld, 0);
    chk("arst_out_dat", out_dat, 0);
    chk("arst_out_lst", out_lst, 0);
    chk("arst_in_rdy", in_rdy, 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_txn(IMG, 5, 1'b0, 1, 0, 0);

    for (int t = 0; t < 25; t++) begin
      @(negedge clk);
      run_txn({$urandom, $urandom},
              int'($urandom_range(0, WA - 1)),
              1'($urandom_range(0, 1)),
              int'($urandom_range(0, 15)),
              2, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
